// File: rtl/acf_pkg.sv
// Shared definitions for the autocorrelation path: sequencer state encoding,
// default block geometry and the ACF result payload handed to the Levinson stage.
package acf_pkg;

  localparam int unsigned DEF_BLOCK_SIZE   = 4096;
  localparam int unsigned DEF_DRAIN_CYCLES = 26;
  localparam int unsigned DEF_SAMPLE_W     = 16;
  localparam int unsigned DEF_ACF_W        = 32;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    DRAIN,
    HOLD,
    CLEAR
  } acf_state_t;

  // Four autocorrelation lags of one block, lag 0 in the low word.
  typedef struct packed {
    logic signed [DEF_ACF_W-1:0] acf3;
    logic signed [DEF_ACF_W-1:0] acf2;
    logic signed [DEF_ACF_W-1:0] acf1;
    logic signed [DEF_ACF_W-1:0] acf0;
  } acf_result_t;

endpackage : acf_pkg

// File: rtl/autocorrelation_sequencer.sv
// Block-level controller for the autocorrelation engine. Feeds exactly one
// block of samples into the engine, keeps it enabled through its pipeline
// drain, captures the four ACF words and offers them downstream; the engine is
// held in reset between blocks.
//
// Ports:
//   iClock, iReset        clock (rising edge), asynchronous active-low reset
//   iEnable               start/continue blocks, sampled in IDLE and CLEAR
//   iSample/iValid/oReady upstream sample stream (accept = iValid & oReady)
//   oAcfEnable/oAcfReset/oAcfSample   engine control and sample inputs
//   iACF0..iACF3          engine results
//   oACF0..oACF3/oValid/iReady        captured results to the Levinson stage
//   oBlockCount           completed-block counter (wraps)
module autocorrelation_sequencer
  import acf_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE   = DEF_BLOCK_SIZE,
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int unsigned SAMPLE_W     = DEF_SAMPLE_W,
  parameter int unsigned ACF_W        = DEF_ACF_W
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iEnable,
  input  logic signed [SAMPLE_W-1:0] iSample,
  input  logic                       iValid,
  output logic                       oReady,
  output logic                       oAcfEnable,
  output logic                       oAcfReset,
  output logic signed [SAMPLE_W-1:0] oAcfSample,
  input  logic signed [ACF_W-1:0]    iACF0,
  input  logic signed [ACF_W-1:0]    iACF1,
  input  logic signed [ACF_W-1:0]    iACF2,
  input  logic signed [ACF_W-1:0]    iACF3,
  output logic signed [ACF_W-1:0]    oACF0,
  output logic signed [ACF_W-1:0]    oACF1,
  output logic signed [ACF_W-1:0]    oACF2,
  output logic signed [ACF_W-1:0]    oACF3,
  output logic                       oValid,
  input  logic                       iReady,
  output logic [15:0]                oBlockCount
);

  localparam int unsigned SAMPLE_CNT_W = $clog2(BLOCK_SIZE);
  localparam int unsigned DRAIN_CNT_W  = $clog2(DRAIN_CYCLES + 1);
  localparam logic [SAMPLE_CNT_W-1:0] LAST_SAMPLE = SAMPLE_CNT_W'(BLOCK_SIZE - 1);
  localparam logic [DRAIN_CNT_W-1:0]  LAST_DRAIN  = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  acf_state_t              state;
  logic [SAMPLE_CNT_W-1:0] sample_cnt;
  logic [DRAIN_CNT_W-1:0]  drain_cnt;

  // Pure decodes of the state register; reset state IDLE keeps the engine in
  // reset while iReset is asserted.
  assign oReady    = (state == FEED);
  assign oAcfReset = (state == IDLE) || (state == CLEAR);

  // Sequencer FSM with registered engine controls and result capture.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      drain_cnt   <= '0;
      oAcfEnable  <= 1'b0;
      oAcfSample  <= '0;
      oACF0       <= '0;
      oACF1       <= '0;
      oACF2       <= '0;
      oACF3       <= '0;
      oValid      <= 1'b0;
      oBlockCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          oAcfEnable <= 1'b0;
          if (iEnable) begin
            state <= FEED;
          end
        end

        // Engine advances only on cycles that carry an accepted sample.
        FEED: begin
          if (iValid) begin
            oAcfSample <= iSample;
            oAcfEnable <= 1'b1;
            if (sample_cnt == LAST_SAMPLE) begin
              sample_cnt <= '0;
              state      <= DRAIN;
            end else begin
              sample_cnt <= sample_cnt + SAMPLE_CNT_W'(1);
            end
          end else begin
            oAcfEnable <= 1'b0;
          end
        end

        // Flush the engine pipeline with zero samples, then capture.
        DRAIN: begin
          oAcfEnable <= 1'b1;
          oAcfSample <= '0;
          if (drain_cnt == LAST_DRAIN) begin
            drain_cnt <= '0;
            oACF0     <= iACF0;
            oACF1     <= iACF1;
            oACF2     <= iACF2;
            oACF3     <= iACF3;
            oValid    <= 1'b1;
            state     <= HOLD;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_CNT_W'(1);
          end
        end

        HOLD: begin
          oAcfEnable <= 1'b0;
          if (iReady) begin
            oValid      <= 1'b0;
            oBlockCount <= oBlockCount + 16'd1;
            state       <= CLEAR;
          end
        end

        CLEAR: begin
          oAcfEnable <= 1'b0;
          state      <= iEnable ? FEED : IDLE;
        end

        default: begin
          oAcfEnable <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule : autocorrelation_sequencer

// File: tb/tb_autocorrelation_sequencer.sv
// Directed bench for autocorrelation_sequencer with BLOCK_SIZE=8,
// DRAIN_CYCLES=4 and a counting stub in place of the engine.
module tb_autocorrelation_sequencer;

  localparam int unsigned BS = 8;
  localparam int unsigned DC = 4;
  localparam int unsigned SW = 16;
  localparam int unsigned AW = 32;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en    = 1'b0;
  logic                 valid = 1'b0;
  logic                 ready = 1'b0;
  logic signed [SW-1:0] samp  = '0;

  logic                 rdy;
  logic                 acf_enable;
  logic                 acf_reset;
  logic signed [SW-1:0] acf_sample;
  logic signed [AW-1:0] a0, a1, a2, a3;
  logic signed [AW-1:0] r0, r1, r2, r3;
  logic                 res_valid;
  logic [15:0]          block_count;

  autocorrelation_sequencer #(
    .BLOCK_SIZE  (BS),
    .DRAIN_CYCLES(DC),
    .SAMPLE_W    (SW),
    .ACF_W       (AW)
  ) dut (
    .iClock     (clk),
    .iReset     (rst_n),
    .iEnable    (en),
    .iSample    (samp),
    .iValid     (valid),
    .oReady     (rdy),
    .oAcfEnable (acf_enable),
    .oAcfReset  (acf_reset),
    .oAcfSample (acf_sample),
    .iACF0      (a0),
    .iACF1      (a1),
    .iACF2      (a2),
    .iACF3      (a3),
    .oACF0      (r0),
    .oACF1      (r1),
    .oACF2      (r2),
    .oACF3      (r3),
    .oValid     (res_valid),
    .iReady     (ready),
    .oBlockCount(block_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Engine stub: counts enabled cycles since its reset, crediting an enable
  // still asserted, so a block of 8 samples + 4 drain cycles reads 12 at the
  // capture edge. Lanes 1..3 carry a tag in the top byte to expose swaps.
  logic [AW-1:0] stub_cnt;
  logic [AW-1:0] stub_val;
  always @(negedge clk) begin
    if (acf_reset) stub_cnt <= '0;
    else if (acf_enable) stub_cnt <= stub_cnt + 1;
  end
  assign stub_val = stub_cnt + AW'(acf_enable);
  assign a0 = stub_val;
  assign a1 = stub_val | 32'h0100_0000;
  assign a2 = stub_val | 32'h0200_0000;
  assign a3 = stub_val | 32'h0300_0000;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_result(input string tag);
    check({tag, "_acf0"}, 64'(r0), 64'h0000_000C);
    check({tag, "_acf1"}, 64'(r1), 64'h0100_000C);
    check({tag, "_acf2"}, 64'(r2), 64'h0200_000C);
    check({tag, "_acf3"}, 64'(r3), 64'h0300_000C);
  endtask

  logic signed [SW-1:0] last_samp = '0;
  int                   valid_cyc = 0;

  // One block from FEED through CLEAR. Called and returning on a negedge.
  task automatic run_block(input bit bubbles, input int hold_cycles, input int abort_at,
                           input bit drop_en, input logic [15:0] cnt_after);
    int                   acc = 0;
    int                   iter = 0;
    logic                 r;
    logic                 v;
    logic signed [SW-1:0] s;
    ready = (hold_cycles == 0);
    while (acc < int'(BS) && iter < 64) begin
      r = rdy;
      valid = bubbles ? ((iter % 2) == 0) : 1'b1;
      samp = bubbles ? SW'(16'sh7F00 - 16'(acc * 257)) : SW'(acc + 1);
      if (bubbles && (acc % 2) == 1) samp = -samp;
      v = valid;
      s = samp;
      if (drop_en && acc == 3) en = 1'b0;
      @(negedge clk);
      iter++;
      if (r && v) begin
        acc++;
        check("feed_en", 64'(acf_enable), 64'd1);
        check("feed_samp", 64'(acf_sample), 64'(s));
        last_samp = s;
      end else if (r) begin
        check("bubble_en", 64'(acf_enable), 64'd0);
        check("bubble_hold", 64'(acf_sample), 64'(last_samp));
      end
    end
    valid = 1'b0;
    check("feed_accepts", 64'(acc), 64'(BS));
    if (acc != int'(BS)) return;

    for (int d = 1; d <= int'(DC); d++) begin
      @(negedge clk);
      check("drain_en", 64'(acf_enable), 64'd1);
      check("drain_samp", 64'(acf_sample), 64'd0);
      check("drain_valid", 64'(res_valid), 64'(d == int'(DC)));
      check("drain_rdy", 64'(rdy), 64'd0);
      if (abort_at == d) begin
        rst_n = 1'b0;
        #1;
        check("abort_reset", 64'(acf_reset), 64'd1);
        check("abort_valid", 64'(res_valid), 64'd0);
        check("abort_en", 64'(acf_enable), 64'd0);
        check("abort_rdy", 64'(rdy), 64'd0);
        check("abort_count", 64'(block_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_samp = '0;
        return;
      end
    end
    last_samp = '0;
    valid_cyc = cyc;
    check_result("capture");

    if (hold_cycles > 0) begin
      valid = 1'b1;
      for (int h = 0; h < hold_cycles; h++) begin
        @(negedge clk);
        check("hold_valid", 64'(res_valid), 64'd1);
        check("hold_acf0", 64'(r0), 64'h0000_000C);
        check("hold_acf3", 64'(r3), 64'h0300_000C);
        check("hold_rdy", 64'(rdy), 64'd0);
        check("hold_en", 64'(acf_enable), 64'd0);
      end
      valid = 1'b0;
      ready = 1'b1;
    end

    @(negedge clk);
    check("clear_valid", 64'(res_valid), 64'd0);
    check("clear_count", 64'(block_count), 64'(cnt_after));
    check("clear_reset", 64'(acf_reset), 64'd1);
    check("clear_rdy", 64'(rdy), 64'd0);
  endtask

  int first_cyc;

  initial begin
    // Reset held: every output at its reset value, engine in reset.
    repeat (3) @(negedge clk);
    check("rst_rdy", 64'(rdy), 64'd0);
    check("rst_acf_reset", 64'(acf_reset), 64'd1);
    check("rst_acf_en", 64'(acf_enable), 64'd0);
    check("rst_samp", 64'(acf_sample), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_count", 64'(block_count), 64'd0);
    check("rst_acf0", 64'(r0), 64'd0);
    check("rst_acf3", 64'(r3), 64'd0);

    // Released with iEnable low: stays IDLE.
    rst_n = 1'b1;
    valid = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_rdy", 64'(rdy), 64'd0);
    check("idle_reset", 64'(acf_reset), 64'd1);
    check("idle_en", 64'(acf_enable), 64'd0);
    valid = 1'b0;

    // Streaming block with 10 cycles of downstream backpressure.
    en = 1'b1;
    run_block(1'b0, 10, 0, 1'b0, 16'd1);
    // Bubbled input stream.
    run_block(1'b1, 0, 0, 1'b0, 16'd2);
    // Back-to-back blocks: result period is BS + DC + 2.
    run_block(1'b0, 0, 0, 1'b0, 16'd3);
    first_cyc = valid_cyc;
    run_block(1'b0, 0, 0, 1'b0, 16'd4);
    check("b2b_period", 64'(valid_cyc - first_cyc), 64'(BS + DC + 2));
    // Reset during the second drain cycle discards the block.
    run_block(1'b0, 0, 2, 1'b0, 16'd0);
    check("post_abort_reset", 64'(acf_reset), 64'd1);
    run_block(1'b0, 0, 0, 1'b0, 16'd1);
    // iEnable dropped mid-block: block completes, then IDLE.
    run_block(1'b0, 0, 0, 1'b1, 16'd2);
    repeat (2) begin
      @(negedge clk);
      check("end_idle_reset", 64'(acf_reset), 64'd1);
      check("end_idle_rdy", 64'(rdy), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_autocorrelation_sequencer
